// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding, grid constants and paddle-window helper
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_POINT = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   localparam int GRID_MAX    = 15;
   localparam int GRID_CENTRE = 8;
   localparam int SPEED_W     = 5;

   // Window is computed in 5 bits and clipped so a paddle near the bottom never wraps to row 0.
   function automatic logic pad_hit(input logic [3:0] pad, input logic [3:0] y, input int h);
      logic [4:0] w_top;
      logic [4:0] w_bot;
      w_top = {1'b0, pad};
      w_bot = w_top + 5'(h - 1);
      if (w_bot > 5'(GRID_MAX))
         w_bot = 5'(GRID_MAX);
      return ({1'b0, y} >= w_top) && ({1'b0, y} <= w_bot);
   endfunction

endpackage

// File: rtl/pong_rally_ctrl_if.sv
// rtl/pong_rally_ctrl_if.sv - player/paddle/ball-datapath signals of the rally controller
interface pong_rally_ctrl_if;
   import pong_pkg::*;

   logic                      start;
   logic [3:0]                ball_x;
   logic [3:0]                ball_y;
   logic [3:0]                pad_l;
   logic [3:0]                pad_r;
   logic                      ball_reset;
   logic signed [SPEED_W-1:0] ball_speed;
   logic [3:0]                score_l;
   logic [3:0]                score_r;
   logic [2:0]                state;
   logic                      hit_pulse;

   modport master (
      input  start, ball_x, ball_y, pad_l, pad_r,
      output ball_reset, ball_speed, score_l, score_r, state, hit_pulse
   );

   modport slave (
      output start, ball_x, ball_y, pad_l, pad_r,
      input  ball_reset, ball_speed, score_l, score_r, state, hit_pulse
   );

endinterface

// File: rtl/pong_tick_timer.sv
// rtl/pong_tick_timer.sv - loadable down-counter with zero flag, shared by SERVE and POINT
module pong_tick_timer #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset)
         r_count <= '0;
      else if (i_load)
         r_count <= i_value;
      else if (r_count != '0)
         r_count <= r_count - W'(1);
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/pong_rally_ctrl.sv
// rtl/pong_rally_ctrl.sv - pong game sequencer: serve hold, hit/miss judging, scores, speed ramp
module pong_rally_ctrl
   import pong_pkg::*;
#(
   parameter int SERVE_TICKS   = 2000,
   parameter int POINT_TICKS   = 1000,
   parameter int WIN_SCORE     = 9,
   parameter int PADDLE_H      = 4,
   parameter int SPEED_INIT    = 4,
   parameter int SPEED_MAX     = 15,
   parameter int HITS_PER_STEP = 4
) (
   input  logic               clk,
   input  logic               reset,
   pong_rally_ctrl_if.master  io_game
);

   localparam int TMR_MAX = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
   localparam int TMR_W   = $clog2(TMR_MAX);
   localparam int HIT_W   = $clog2(HITS_PER_STEP + 1);

   state_t                    r_state;
   logic                      r_ball_reset;
   logic                      r_hit_pulse;
   logic                      r_serve_left;
   logic signed [SPEED_W-1:0] r_ball_speed;
   logic [SPEED_W-1:0]        r_mag;
   logic [3:0]                r_score_l;
   logic [3:0]                r_score_r;
   logic [3:0]                r_prev_x;
   logic [HIT_W-1:0]          r_hits;

   logic                      w_tmr_load;
   logic                      w_tmr_zero;
   logic [TMR_W-1:0]          w_tmr_val;
   logic                      w_start_go;
   logic                      w_point_done;
   logic                      w_left_ev;
   logic                      w_right_ev;
   logic                      w_left_hit;
   logic                      w_right_hit;
   logic                      w_miss;
   logic [3:0]                w_score_l_nx;
   logic [3:0]                w_score_r_nx;
   logic [SPEED_W-1:0]        w_mag_up;

   assign w_start_go   = io_game.start && (r_state == ST_IDLE || r_state == ST_OVER);
   assign w_point_done = (r_state == ST_POINT) && w_tmr_zero;
   assign w_left_ev    = (r_state == ST_PLAY) && (io_game.ball_x == 4'd0) && (r_prev_x != 4'd0);
   assign w_right_ev   = (r_state == ST_PLAY) && (io_game.ball_x == 4'(GRID_MAX))
                         && (r_prev_x != 4'(GRID_MAX));
   assign w_left_hit   = pad_hit(io_game.pad_l, io_game.ball_y, PADDLE_H);
   assign w_right_hit  = pad_hit(io_game.pad_r, io_game.ball_y, PADDLE_H);
   // Left column wins if both events were ever forced in one cycle.
   assign w_miss       = w_left_ev ? !w_left_hit : (w_right_ev && !w_right_hit);
   assign w_score_l_nx = r_score_l + 4'd1;
   assign w_score_r_nx = r_score_r + 4'd1;
   assign w_mag_up     = (r_mag >= SPEED_W'(SPEED_MAX)) ? r_mag : r_mag + SPEED_W'(1);

   assign w_tmr_load   = w_start_go || w_point_done || w_miss;
   assign w_tmr_val    = w_miss ? TMR_W'(POINT_TICKS - 1) : TMR_W'(SERVE_TICKS - 1);

   pong_tick_timer #(.W(TMR_W)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_tmr_load),
      .i_value (w_tmr_val),
      .o_zero  (w_tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_ball_reset <= 1'b1;
         r_ball_speed <= SPEED_W'(SPEED_INIT);
         r_mag        <= SPEED_W'(SPEED_INIT);
         r_score_l    <= 4'd0;
         r_score_r    <= 4'd0;
         r_hit_pulse  <= 1'b0;
         r_hits       <= '0;
         r_serve_left <= 1'b0;
         r_prev_x     <= 4'(GRID_CENTRE);
      end else begin
         r_hit_pulse <= 1'b0;
         // Centre value while the ball is held, so release never looks like a column entry.
         r_prev_x    <= r_ball_reset ? 4'(GRID_CENTRE) : io_game.ball_x;
         case (r_state)
            ST_IDLE, ST_OVER: begin
               if (io_game.start) begin
                  r_state   <= ST_SERVE;
                  r_score_l <= 4'd0;
                  r_score_r <= 4'd0;
               end
            end
            ST_SERVE: begin
               if (w_tmr_zero) begin
                  r_state      <= ST_PLAY;
                  r_ball_reset <= 1'b0;
                  r_mag        <= SPEED_W'(SPEED_INIT);
                  r_ball_speed <= r_serve_left ? -SPEED_W'(SPEED_INIT) : SPEED_W'(SPEED_INIT);
                  r_hits       <= '0;
               end
            end
            ST_PLAY: begin
               if (w_left_ev || w_right_ev) begin
                  if (!w_miss) begin
                     r_hit_pulse <= 1'b1;
                     if (r_hits == HIT_W'(HITS_PER_STEP - 1)) begin
                        r_hits       <= '0;
                        r_mag        <= w_mag_up;
                        r_ball_speed <= r_ball_speed[SPEED_W-1] ? -w_mag_up : w_mag_up;
                     end else begin
                        r_hits <= r_hits + HIT_W'(1);
                     end
                  end else if (w_left_ev) begin
                     r_score_r    <= w_score_r_nx;
                     r_serve_left <= 1'b1;
                     r_ball_reset <= 1'b1;
                     r_state      <= (w_score_r_nx == 4'(WIN_SCORE)) ? ST_OVER : ST_POINT;
                  end else begin
                     r_score_l    <= w_score_l_nx;
                     r_serve_left <= 1'b0;
                     r_ball_reset <= 1'b1;
                     r_state      <= (w_score_l_nx == 4'(WIN_SCORE)) ? ST_OVER : ST_POINT;
                  end
               end
            end
            ST_POINT: begin
               if (w_tmr_zero)
                  r_state <= ST_SERVE;
            end
            default: begin
               r_state      <= ST_IDLE;
               r_ball_reset <= 1'b1;
            end
         endcase
      end
   end

   assign io_game.ball_reset = r_ball_reset;
   assign io_game.ball_speed = r_ball_speed;
   assign io_game.score_l    = r_score_l;
   assign io_game.score_r    = r_score_r;
   assign io_game.state      = r_state;
   assign io_game.hit_pulse  = r_hit_pulse;

endmodule

// File: tb/tb_pong_rally_ctrl.sv
// tb/tb_pong_rally_ctrl.sv - vector table, corner sequences and randomized run against a game model
module tb_pong_rally_ctrl;
   import pong_pkg::*;

   localparam int SERVE_T = 2000;
   localparam int POINT_T = 1000;
   localparam int WIN     = 9;
   localparam int PH      = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pong_rally_ctrl_if bus();

   pong_rally_ctrl dut (
      .clk     (clk),
      .reset   (reset),
      .io_game (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference game state, kept as plain integers.
   int m_st, m_cnt, m_sl, m_sr, m_mag, m_spd, m_hits, m_prev, m_br, m_hit, m_sleft;

   typedef struct {
      int bx, by, pl, pr;
      int hit, spd, sl, sr, st;
   } vec_t;
   vec_t tbl[17];

   function automatic bit in_win(int pad, int y);
      int bot;
      bot = (pad + PH - 1 > 15) ? 15 : pad + PH - 1;
      return (y >= pad) && (y <= bot);
   endfunction

   task automatic model_step();
      int nprev, bx, by, side, pad;
      bit won;
      bx    = int'(bus.ball_x);
      by    = int'(bus.ball_y);
      nprev = (m_br != 0) ? 8 : bx;
      m_hit = 0;
      if (reset) begin
         m_st = 0; m_br = 1; m_spd = 4; m_mag = 4; m_sl = 0; m_sr = 0;
         m_cnt = 0; m_hits = 0; m_sleft = 0; nprev = 8;
      end else begin
         case (m_st)
            0, 4: if (bus.start) begin m_st = 1; m_cnt = SERVE_T - 1; m_sl = 0; m_sr = 0; end
            1: begin
               if (m_cnt == 0) begin
                  m_st = 2; m_br = 0; m_mag = 4; m_hits = 0;
                  m_spd = (m_sleft != 0) ? -4 : 4;
               end else m_cnt--;
            end
            2: begin
               side = 0;
               if (bx == 0 && m_prev != 0) side = 1;
               else if (bx == 15 && m_prev != 15) side = 2;
               if (side != 0) begin
                  pad = (side == 1) ? int'(bus.pad_l) : int'(bus.pad_r);
                  if (in_win(pad, by)) begin
                     m_hit = 1;
                     m_hits++;
                     if (m_hits == 4) begin
                        m_hits = 0;
                        if (m_mag < 15) m_mag++;
                        m_spd = (m_spd < 0) ? -m_mag : m_mag;
                     end
                  end else begin
                     if (side == 1) begin m_sr++; m_sleft = 1; won = (m_sr == WIN); end
                     else begin m_sl++; m_sleft = 0; won = (m_sl == WIN); end
                     m_br = 1; m_cnt = POINT_T - 1;
                     m_st = won ? 4 : 3;
                  end
               end
            end
            3: begin
               if (m_cnt == 0) begin m_st = 1; m_cnt = SERVE_T - 1; end
               else m_cnt--;
            end
            default: m_st = 0;
         endcase
      end
      m_prev = nprev;
   endtask

   task automatic check_model();
      total++;
      if ($isunknown({bus.ball_reset, bus.ball_speed, bus.score_l, bus.score_r, bus.state, bus.hit_pulse})
          || int'(bus.ball_reset) != m_br || int'(bus.ball_speed) != m_spd
          || int'(bus.score_l) != m_sl || int'(bus.score_r) != m_sr
          || int'(bus.state) != m_st || int'(bus.hit_pulse) != m_hit) begin
         bad++;
         if (bad < 30)
            $display("FAIL model t=%0t got br=%0d spd=%0d sl=%0d sr=%0d st=%0d hit=%0d want br=%0d spd=%0d sl=%0d sr=%0d st=%0d hit=%0d",
                     $time, bus.ball_reset, bus.ball_speed, bus.score_l, bus.score_r, bus.state, bus.hit_pulse,
                     m_br, m_spd, m_sl, m_sr, m_st, m_hit);
      end
   endtask

   task automatic chk(string name, int got, int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic set_in(int bx, int by, int pl, int pr);
      bus.ball_x = 4'(bx);
      bus.ball_y = 4'(by);
      bus.pad_l  = 4'(pl);
      bus.pad_r  = 4'(pr);
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   task automatic wait_leave(int st, int bound, output int n);
      n = 0;
      while (int'(bus.state) == st && n < bound) begin
         step();
         n++;
      end
   endtask

   task automatic serve_again(string tag);
      int n;
      set_in(8, 8, 0, 0);
      wait_leave(3, POINT_T + 50, n);
      chk({tag, "_point_len"}, n, POINT_T);
      wait_leave(1, SERVE_T + 50, n);
      chk({tag, "_serve_len"}, n, SERVE_T);
   endtask

   task automatic right_miss();
      set_in(14, 0, 0, 14);
      step();
      set_in(15, 0, 0, 14);
      step();
   endtask

   initial begin
      int n;
      tbl[0]  = '{14, 7, 0, 5, 0, 4, 0, 0, 2};
      tbl[1]  = '{15, 7, 0, 5, 1, 4, 0, 0, 2};
      tbl[2]  = '{15, 7, 0, 5, 0, 4, 0, 0, 2};
      tbl[3]  = '{15, 7, 0, 5, 0, 4, 0, 0, 2};
      tbl[4]  = '{14, 7, 0, 5, 0, 4, 0, 0, 2};
      tbl[5]  = '{15, 7, 0, 5, 1, 4, 0, 0, 2};
      tbl[6]  = '{14, 7, 0, 5, 0, 4, 0, 0, 2};
      tbl[7]  = '{15, 7, 0, 5, 1, 4, 0, 0, 2};
      tbl[8]  = '{14, 7, 0, 5, 0, 4, 0, 0, 2};
      tbl[9]  = '{15, 7, 0, 5, 1, 5, 0, 0, 2};
      tbl[10] = '{15, 7, 0, 5, 0, 5, 0, 0, 2};
      tbl[11] = '{14, 15, 0, 14, 0, 5, 0, 0, 2};
      tbl[12] = '{15, 15, 0, 14, 1, 5, 0, 0, 2};
      tbl[13] = '{1, 5, 2, 14, 0, 5, 0, 0, 2};
      tbl[14] = '{0, 5, 2, 14, 1, 5, 0, 0, 2};
      tbl[15] = '{1, 12, 2, 14, 0, 5, 0, 0, 2};
      tbl[16] = '{0, 12, 2, 14, 0, 5, 0, 1, 3};

      reset = 1'b1;
      bus.start = 1'b0;
      set_in(8, 8, 0, 0);
      step();
      step();
      chk("reset_state", int'(bus.state), 0);
      chk("reset_ball_reset", int'(bus.ball_reset), 1);
      chk("reset_speed", int'(bus.ball_speed), 4);
      chk("reset_scores", int'(bus.score_l) + int'(bus.score_r), 0);
      reset = 1'b0;
      step();
      chk("idle_hold", int'(bus.state), 0);

      // Serve from IDLE and release.
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("start_serve", int'(bus.state), 1);
      wait_leave(1, SERVE_T + 50, n);
      chk("serve_len", n, SERVE_T);
      chk("play_state", int'(bus.state), 2);
      chk("play_speed", int'(bus.ball_speed), 4);
      chk("play_release", int'(bus.ball_reset), 0);

      for (int i = 0; i < 17; i++) begin
         set_in(tbl[i].bx, tbl[i].by, tbl[i].pl, tbl[i].pr);
         step();
         chk($sformatf("vec%0d_hit", i), int'(bus.hit_pulse), tbl[i].hit);
         chk($sformatf("vec%0d_spd", i), int'(bus.ball_speed), tbl[i].spd);
         chk($sformatf("vec%0d_score", i), int'(bus.score_l) * 16 + int'(bus.score_r),
             tbl[i].sl * 16 + tbl[i].sr);
         chk($sformatf("vec%0d_state", i), int'(bus.state), tbl[i].st);
      end

      // Left miss serves toward the loser.
      serve_again("left_miss");
      chk("serve_left_speed", int'(bus.ball_speed), -4);

      // Run the left player up to the winning score.
      for (int i = 1; i <= WIN; i++) begin
         right_miss();
         chk("right_miss_score", int'(bus.score_l), i);
         if (i < WIN) begin
            chk("right_miss_point", int'(bus.state), 3);
            serve_again("right_miss");
            chk("serve_right_speed", int'(bus.ball_speed), 4);
         end
      end
      chk("over_state", int'(bus.state), 4);
      chk("over_ball_reset", int'(bus.ball_reset), 1);
      chk("over_score_r", int'(bus.score_r), 1);
      set_in(8, 8, 0, 0);
      for (int i = 0; i < 5; i++) step();
      chk("over_frozen", int'(bus.state) * 16 + int'(bus.score_l), 4 * 16 + WIN);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("restart_state", int'(bus.state), 1);
      chk("restart_scores", int'(bus.score_l) + int'(bus.score_r), 0);
      wait_leave(1, SERVE_T + 50, n);
      chk("restart_serve_len", n, SERVE_T);

      // Ramp speed to +7, then reset mid-rally.
      right_miss();
      serve_again("ramp");
      for (int i = 0; i < 12; i++) begin
         set_in(14, 7, 0, 5);
         step();
         set_in(15, 7, 0, 5);
         step();
      end
      chk("ramp_speed", int'(bus.ball_speed), 7);
      chk("ramp_score_l", int'(bus.score_l), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midplay_reset_state", int'(bus.state), 0);
      chk("midplay_reset_speed", int'(bus.ball_speed), 4);
      chk("midplay_reset_scores", int'(bus.score_l) + int'(bus.score_r), 0);
      chk("midplay_reset_br", int'(bus.ball_reset), 1);

      // Randomized play checked every cycle against the model.
      for (int c = 0; c < 16000; c++) begin
         int pl, pr, by;
         pl = int'($urandom_range(0, 15));
         pr = int'($urandom_range(0, 15));
         by = ($urandom_range(0, 1) != 0) ? ((pr + int'($urandom_range(0, 5))) & 15)
                                          : int'($urandom_range(0, 15));
         set_in(int'($urandom_range(0, 15)), by, pl, pr);
         bus.start = ($urandom_range(0, 49) == 0);
         reset     = ($urandom_range(0, 5999) == 0);
         step();
      end
      reset = 1'b0;
      bus.start = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
